// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between two requesters.
// Optional grant counters are enabled with LU_PERF_CNT_EN.
module logic_unit_arbiter #(
    parameter int WIDTH = 16
`ifdef LU_PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data
`ifdef LU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    state_t state_nx;

    logic             accept;
    logic             prio;
    logic             grant;
    logic             win;
    logic [1:0]       win_op;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [WIDTH-1:0] result;

    // Slot occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Slot fills on any grant, drains when consumer takes it without refill
    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: begin
                if (grant) state_nx = FULL;
            end
            FULL: begin
                if (grant) begin
                    state_nx = FULL;
                end else if (resp_ready) begin
                    state_nx = EMPTY;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    // Slot outputs and acceptance (drain and refill in the same cycle)
    always_comb begin
        resp_valid = (state == FULL);
        accept     = (state == EMPTY) || resp_ready;
    end

    // Round-robin pick: sole requester wins, contention resolved by prio
    always_comb begin
        grant = 1'b0;
        win   = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = accept;
            win   = prio;
        end else if (req0_valid) begin
            grant = accept;
            win   = 1'b0;
        end else if (req1_valid) begin
            grant = accept;
            win   = 1'b1;
        end
        req0_ready = grant && !win;
        req1_ready = grant && win;
    end

    // Operand mux and the shared bitwise datapath
    always_comb begin
        win_op = win ? req1_op : req0_op;
        win_a  = win ? req1_a  : req0_a;
        win_b  = win ? req1_b  : req0_b;
        unique case (win_op)
            2'b00:   result = win_a | win_b;
            2'b01:   result = win_a & win_b;
            2'b10:   result = win_a ^ win_b;
            2'b11:   result = win_a & ~win_b;
            default: result = '0;
        endcase
    end

    // Capture winner result and rotate priority away from the winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data <= '0;
            resp_id   <= 1'b0;
            prio      <= 1'b0;
        end else if (grant) begin
            resp_data <= result;
            resp_id   <= win;
            prio      <= ~win;
        end
    end

`ifdef LU_PERF_CNT_EN
    // Saturating per-requester grant counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (grant) begin
            if (!win && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 1'b1;
            if (win && (grant_cnt1 != '1))  grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end
`endif

endmodule
